// File: rtl/decode_pkg.sv
// Shared opcode/funct encodings, ALU operation codes and the D->E control bundle
// for the registered MIPS main decoder.
package decode_pkg;

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_ADDIU  = 6'b001001;
  localparam logic [5:0] OP_SLTI   = 6'b001010;
  localparam logic [5:0] OP_SLTIU  = 6'b001011;
  localparam logic [5:0] OP_ANDI   = 6'b001100;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_XORI   = 6'b001110;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_MUL  = 6'b011000;
  localparam logic [5:0] FN_MULU = 6'b011001;
  localparam logic [5:0] FN_DIV  = 6'b011010;
  localparam logic [5:0] FN_DIVU = 6'b011011;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  localparam logic [4:0] ALU_AND  = 5'b00000;
  localparam logic [4:0] ALU_OR   = 5'b00001;
  localparam logic [4:0] ALU_ADDU = 5'b00010;
  localparam logic [4:0] ALU_DIV  = 5'b00011;
  localparam logic [4:0] ALU_MUL  = 5'b00100;
  localparam logic [4:0] ALU_SLL  = 5'b00101;
  localparam logic [4:0] ALU_SUBU = 5'b00110;
  localparam logic [4:0] ALU_SLT  = 5'b00111;
  localparam logic [4:0] ALU_SRL  = 5'b01000;
  localparam logic [4:0] ALU_XOR  = 5'b01001;
  localparam logic [4:0] ALU_SLTU = 5'b01010;
  localparam logic [4:0] ALU_SRA  = 5'b01011;
  localparam logic [4:0] ALU_BNE  = 5'b01101;
  localparam logic [4:0] ALU_BGEZ = 5'b01110;
  localparam logic [4:0] ALU_BGTZ = 5'b01111;
  localparam logic [4:0] ALU_BLEZ = 5'b10000;
  localparam logic [4:0] ALU_BLTZ = 5'b10001;
  localparam logic [4:0] ALU_ADD  = 5'b10010;
  localparam logic [4:0] ALU_SUB  = 5'b10011;
  localparam logic [4:0] ALU_DIVU = 5'b10100;
  localparam logic [4:0] ALU_MULU = 5'b10101;

  typedef struct packed {
    logic       reg_write;
    logic       memto_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_dst;
    logic       shift_imm;
    logic [4:0] alu_control;
    logic       valid;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/decode_comb.sv
// Purely combinational main decode: opcode/funct/rt to the control bundle,
// branch flag and the extra E-stage cycles an MDU op needs.
module decode_comb
  import decode_pkg::*;
#(
  parameter int CNT_W   = 4,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 16
) (
  input  logic [5:0]       op_code,
  input  logic [5:0]       funct,
  input  logic [4:0]       rt,
  output ctrl_t            ctrl,
  output logic             branch,
  output logic [CNT_W-1:0] mdu_lat
);

  always_comb begin
    ctrl    = '0;
    branch  = 1'b0;
    mdu_lat = '0;
    case (op_code)
      OP_RTYPE: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
        case (funct)
          FN_SLL:  begin ctrl.alu_control = ALU_SLL; ctrl.shift_imm = 1'b1; end
          FN_SRL:  begin ctrl.alu_control = ALU_SRL; ctrl.shift_imm = 1'b1; end
          FN_SRA:  begin ctrl.alu_control = ALU_SRA; ctrl.shift_imm = 1'b1; end
          FN_SLLV: ctrl.alu_control = ALU_SLL;
          FN_SRLV: ctrl.alu_control = ALU_SRL;
          FN_SRAV: ctrl.alu_control = ALU_SRA;
          FN_MUL:  begin ctrl.alu_control = ALU_MUL;  mdu_lat = CNT_W'(MUL_LAT - 1); end
          FN_MULU: begin ctrl.alu_control = ALU_MULU; mdu_lat = CNT_W'(MUL_LAT - 1); end
          FN_DIV:  begin ctrl.alu_control = ALU_DIV;  mdu_lat = CNT_W'(DIV_LAT - 1); end
          FN_DIVU: begin ctrl.alu_control = ALU_DIVU; mdu_lat = CNT_W'(DIV_LAT - 1); end
          FN_ADD:  ctrl.alu_control = ALU_ADD;
          FN_ADDU: ctrl.alu_control = ALU_ADDU;
          FN_SUB:  ctrl.alu_control = ALU_SUB;
          FN_SUBU: ctrl.alu_control = ALU_SUBU;
          FN_AND:  ctrl.alu_control = ALU_AND;
          FN_OR:   ctrl.alu_control = ALU_OR;
          FN_XOR:  ctrl.alu_control = ALU_XOR;
          FN_SLT:  ctrl.alu_control = ALU_SLT;
          FN_SLTU: ctrl.alu_control = ALU_SLTU;
          default: ctrl.illegal = 1'b1;
        endcase
      end
      OP_REGIMM: begin
        branch = 1'b1;
        case (rt)
          5'b00000: ctrl.alu_control = ALU_BLTZ;
          5'b00001: ctrl.alu_control = ALU_BGEZ;
          default:  ctrl.illegal = 1'b1;
        endcase
      end
      OP_BEQ:   begin branch = 1'b1; ctrl.alu_control = ALU_SUBU; end
      OP_BNE:   begin branch = 1'b1; ctrl.alu_control = ALU_BNE;  end
      OP_BLEZ:  begin branch = 1'b1; ctrl.alu_control = ALU_BLEZ; end
      OP_BGTZ:  begin branch = 1'b1; ctrl.alu_control = ALU_BGTZ; end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        case (op_code)
          OP_ADDI:  ctrl.alu_control = ALU_ADD;
          OP_ADDIU: ctrl.alu_control = ALU_ADDU;
          OP_SLTI:  ctrl.alu_control = ALU_SLT;
          OP_SLTIU: ctrl.alu_control = ALU_SLTU;
          OP_ANDI:  ctrl.alu_control = ALU_AND;
          OP_ORI:   ctrl.alu_control = ALU_OR;
          default:  ctrl.alu_control = ALU_XOR;
        endcase
      end
      OP_LW: begin
        ctrl.alu_src     = 1'b1;
        ctrl.memto_reg   = 1'b1;
        ctrl.reg_write   = 1'b1;
        ctrl.alu_control = ALU_ADDU;
      end
      OP_SW: begin
        ctrl.alu_src     = 1'b1;
        ctrl.mem_write   = 1'b1;
        ctrl.alu_control = ALU_ADDU;
      end
      default: ctrl.illegal = 1'b1;
    endcase
    // An illegal instruction travels on as a flagged bubble with nothing enabled.
    if (ctrl.illegal) begin
      ctrl         = '0;
      ctrl.illegal = 1'b1;
      branch       = 1'b0;
      mdu_lat      = '0;
    end
    ctrl.valid = ~ctrl.illegal;
  end

endmodule

// File: rtl/decode_ctrl_e.sv
// D-stage decoder with registered D->E control bundle, bubble insertion and an
// E-stage hold counter for multi-cycle mul/div.
module decode_ctrl_e
  import decode_pkg::*;
#(
  parameter int ALUCTL_W = 5,
  parameter int MUL_LAT  = 4,
  parameter int DIV_LAT  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                instr_valid_d,
  input  logic [5:0]          op_code,
  input  logic [5:0]          funct,
  input  logic [4:0]          rt,
  input  logic                stall_d,
  input  logic                flush_e,
  output logic                branch_d,
  output logic [ALUCTL_W-1:0] alu_control_d,
  output logic                illegal_d,
  output logic                reg_write_e,
  output logic                memto_reg_e,
  output logic                mem_write_e,
  output logic                alu_src_e,
  output logic                reg_dst_e,
  output logic                shift_imm_e,
  output logic [ALUCTL_W-1:0] alu_control_e,
  output logic                valid_e,
  output logic                illegal_e,
  output logic                mdu_busy,
  output logic                stall_mdu
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  ctrl_t            ctrl_p0;
  logic [CNT_W-1:0] mdu_lat_p0;
  ctrl_t            ctrl_p1;
  logic [CNT_W-1:0] cnt_p1;

  decode_comb #(
    .CNT_W   (CNT_W),
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) u_decode_comb (
    .op_code (op_code),
    .funct   (funct),
    .rt      (rt),
    .ctrl    (ctrl_p0),
    .branch  (branch_d),
    .mdu_lat (mdu_lat_p0)
  );

  assign alu_control_d = ALUCTL_W'(ctrl_p0.alu_control);
  assign illegal_d     = ctrl_p0.illegal;

  // D -> E boundary: a non-zero counter freezes E and overrides flush/bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_p1 <= '0;
      cnt_p1  <= '0;
    end else if (cnt_p1 != '0) begin
      cnt_p1 <= cnt_p1 - CNT_W'(1);
    end else if (flush_e || stall_d || !instr_valid_d) begin
      ctrl_p1 <= '0;
    end else begin
      ctrl_p1 <= ctrl_p0;
      cnt_p1  <= mdu_lat_p0;
    end
  end

  assign reg_write_e   = ctrl_p1.reg_write;
  assign memto_reg_e   = ctrl_p1.memto_reg;
  assign mem_write_e   = ctrl_p1.mem_write;
  assign alu_src_e     = ctrl_p1.alu_src;
  assign reg_dst_e     = ctrl_p1.reg_dst;
  assign shift_imm_e   = ctrl_p1.shift_imm;
  assign alu_control_e = ALUCTL_W'(ctrl_p1.alu_control);
  assign valid_e       = ctrl_p1.valid;
  assign illegal_e     = ctrl_p1.illegal;
  assign mdu_busy      = (cnt_p1 != '0);
  assign stall_mdu     = mdu_busy;

endmodule

// File: tb/tb_decode_ctrl_e.sv
// Directed bench for decode_ctrl_e with default parameters (MUL_LAT=4, DIV_LAT=16).
module tb_decode_ctrl_e;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       instr_valid_d;
  logic [5:0] op_code;
  logic [5:0] funct;
  logic [4:0] rt;
  logic       stall_d;
  logic       flush_e;
  logic       branch_d;
  logic [4:0] alu_control_d;
  logic       illegal_d;
  logic       reg_write_e, memto_reg_e, mem_write_e, alu_src_e, reg_dst_e, shift_imm_e;
  logic [4:0] alu_control_e;
  logic       valid_e, illegal_e, mdu_busy, stall_mdu;

  int passed = 0;
  int failed = 0;
  int hold, stalls;

  always #5 clk = ~clk;

  decode_ctrl_e dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instr_valid_d (instr_valid_d),
    .op_code       (op_code),
    .funct         (funct),
    .rt            (rt),
    .stall_d       (stall_d),
    .flush_e       (flush_e),
    .branch_d      (branch_d),
    .alu_control_d (alu_control_d),
    .illegal_d     (illegal_d),
    .reg_write_e   (reg_write_e),
    .memto_reg_e   (memto_reg_e),
    .mem_write_e   (mem_write_e),
    .alu_src_e     (alu_src_e),
    .reg_dst_e     (reg_dst_e),
    .shift_imm_e   (shift_imm_e),
    .alu_control_e (alu_control_e),
    .valid_e       (valid_e),
    .illegal_e     (illegal_e),
    .mdu_busy      (mdu_busy),
    .stall_mdu     (stall_mdu)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; instr_valid_d = 1'b0; op_code = 6'd0; funct = 6'd0; rt = 5'd0;
    stall_d = 1'b0; flush_e = 1'b0;
    #1;
    chk("rst_valid_e", valid_e, 0);
    chk("rst_reg_write_e", reg_write_e, 0);
    chk("rst_mdu_busy", mdu_busy, 0);
    step(); step();
    rst_n = 1'b1;

    // addiu
    instr_valid_d = 1'b1; op_code = 6'b001001;
    #1;
    chk("addiu_illegal_d", illegal_d, 0);
    chk("addiu_branch_d", branch_d, 0);
    step();
    chk("addiu_reg_write_e", reg_write_e, 1);
    chk("addiu_alu_src_e", alu_src_e, 1);
    chk("addiu_reg_dst_e", reg_dst_e, 0);
    chk("addiu_alu_e", alu_control_e, 5'b00010);
    chk("addiu_valid_e", valid_e, 1);
    chk("addiu_memto_e", memto_reg_e, 0);

    // sltu
    op_code = 6'b000000; funct = 6'b101011;
    step();
    chk("sltu_alu_e", alu_control_e, 5'b01010);
    chk("sltu_reg_dst_e", reg_dst_e, 1);
    chk("sltu_alu_src_e", alu_src_e, 0);
    chk("sltu_shift_imm_e", shift_imm_e, 0);

    // sll
    funct = 6'b000000;
    step();
    chk("sll_shift_imm_e", shift_imm_e, 1);
    chk("sll_alu_e", alu_control_e, 5'b00101);

    // REGIMM bgez / illegal rt
    op_code = 6'b000001; rt = 5'd1;
    #1;
    chk("bgez_branch_d", branch_d, 1);
    chk("bgez_alu_d", alu_control_d, 5'b01110);
    chk("bgez_illegal_d", illegal_d, 0);
    step();
    chk("bgez_reg_write_e", reg_write_e, 0);
    chk("bgez_valid_e", valid_e, 1);
    rt = 5'd2;
    #1;
    chk("regimm_rt2_illegal_d", illegal_d, 1);
    chk("regimm_rt2_branch_d", branch_d, 0);

    // beq
    op_code = 6'b000100; rt = 5'd0;
    #1;
    chk("beq_branch_d", branch_d, 1);
    chk("beq_alu_d", alu_control_d, 5'b00110);

    // lw under stall_d becomes a bubble
    op_code = 6'b100011; stall_d = 1'b1;
    step();
    chk("stall_valid_e", valid_e, 0);
    chk("stall_reg_write_e", reg_write_e, 0);
    chk("stall_memto_e", memto_reg_e, 0);
    chk("stall_alu_src_e", alu_src_e, 0);
    stall_d = 1'b0;
    step();
    chk("lw_memto_e", memto_reg_e, 1);
    chk("lw_reg_write_e", reg_write_e, 1);
    chk("lw_alu_src_e", alu_src_e, 1);
    chk("lw_reg_dst_e", reg_dst_e, 0);

    // sw
    op_code = 6'b101011;
    step();
    chk("sw_mem_write_e", mem_write_e, 1);
    chk("sw_reg_write_e", reg_write_e, 0);

    // illegal opcode
    op_code = 6'b111111;
    #1;
    chk("op3f_illegal_d", illegal_d, 1);
    step();
    chk("op3f_illegal_e", illegal_e, 1);
    chk("op3f_reg_write_e", reg_write_e, 0);
    chk("op3f_mem_write_e", mem_write_e, 0);

    // mul: 4 cycles in E, 3 of them stalled
    op_code = 6'b000000; funct = 6'b011000;
    step();
    instr_valid_d = 1'b0;
    chk("mul_alu_e", alu_control_e, 5'b00100);
    hold = 0; stalls = 0;
    if (valid_e && alu_control_e == 5'b00100) hold++;
    if (stall_mdu) stalls++;
    for (int i = 0; i < 30; i++) begin
      step();
      if (valid_e && alu_control_e == 5'b00100) hold++;
      if (stall_mdu) stalls++;
    end
    chk("mul_hold_cycles", hold, 4);
    chk("mul_stall_cycles", stalls, 3);

    // div with a flush pulse mid-hold: 16 cycles, 15 stalled
    instr_valid_d = 1'b1; funct = 6'b011010;
    step();
    instr_valid_d = 1'b0;
    chk("div_alu_e", alu_control_e, 5'b00011);
    hold = 0; stalls = 0;
    if (valid_e && alu_control_e == 5'b00011) hold++;
    if (stall_mdu) stalls++;
    for (int i = 0; i < 30; i++) begin
      flush_e = (i == 3);
      step();
      if (valid_e && alu_control_e == 5'b00011) hold++;
      if (stall_mdu) stalls++;
    end
    flush_e = 1'b0;
    chk("div_hold_cycles", hold, 16);
    chk("div_stall_cycles", stalls, 15);

    // asynchronous reset in the middle of a mul hold
    instr_valid_d = 1'b1; funct = 6'b011000;
    step();
    instr_valid_d = 1'b0;
    chk("mul2_busy", mdu_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", mdu_busy, 0);
    chk("async_rst_stall", stall_mdu, 0);
    chk("async_rst_valid_e", valid_e, 0);
    chk("async_rst_alu_e", alu_control_e, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_valid_e", valid_e, 0);

    $display("%0d/%0d checks passed", passed, passed + failed);
    $finish;
  end

endmodule
